ring_counter_gen: RTL

- Parametrised successor to the fixed 4-bit ring counter.
- Generic N-bit shift counter with run-time ring or Johnson (twisted-ring) mode, direction control, enable, synchronous parallel load and a terminal-count flag.
- Used as a one-hot or phase-sequence generator for sequencers, LED scanners and time-slot selects elsewhere in the design.

---
 rtl/ring_counter_gen.sv | 115 +++++++++++
 1 files changed

// File: rtl/ring_counter_gen.sv
// ----------------------------------------------------------------------------
// ring_counter_gen
//
// Parametrised N-bit shift counter producing one-hot (ring) or phase
// (Johnson / twisted-ring) sequences. Mode, direction, enable and a
// synchronous parallel load are selectable at run time, and a terminal-count
// flag marks the state just before the sequence wraps.
//
// Parameters:
//   WIDTH    counter width in bits (2..32)
//   RST_POS  index of the hot bit in the ring-mode reset pattern
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous, active-high reset (forces the ring reset pattern)
//   en        shift enable
//   dir       0 = shift left (towards MSB), 1 = shift right (towards LSB)
//   mode      0 = ring, 1 = Johnson
//   load      synchronous parallel load strobe
//   load_val  value loaded when load = 1
//   q_out     registered counter state
//   tc        terminal count: the next enabled shift lands on the reset pattern
//   err       illegal-state flag (only driven with the self-correct option)
//
// Optional feature:
//   Define RING_CNT_SELF_CORRECT_EN to add legality checking. err then flags
//   any state that is not a legal code for the current mode, and the next
//   edge (without a mode change or load) restores the mode's reset pattern.
//   Without the macro err is tied to 0 and illegal codes circulate.
// ----------------------------------------------------------------------------
module ring_counter_gen #(
    parameter int WIDTH   = 4,
    parameter int RST_POS = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q_out,
    output logic             tc,
    output logic             err
);

    localparam logic [WIDTH-1:0] RING_RST    = WIDTH'(1) << RST_POS;
    localparam logic [WIDTH-1:0] JOHNSON_RST = '0;

    // Mode the current state was built for; a change on the mode input
    // reinitialises the counter rather than reinterpreting the old state.
    logic             mode_q;
    logic [WIDTH-1:0] rst_pat;
    logic [WIDTH-1:0] shift_q;
    logic             out_bit;
    logic             wrap_bit;

    // NOTE: every signal assigned in an always_comb gets a value on every
    // path; here each is assigned unconditionally, so no latch can appear.
    always_comb begin
        rst_pat  = mode_q ? JOHNSON_RST : RING_RST;
        out_bit  = dir ? q_out[0] : q_out[WIDTH-1];
        // Johnson feeds back the inverse of the bit shifted out.
        wrap_bit = out_bit ^ mode_q;
        shift_q  = dir ? {wrap_bit, q_out[WIDTH-1:1]}
                       : {q_out[WIDTH-2:0], wrap_bit};
    end

    // Both the ring rotate and the twisted-ring shift are permutations of
    // the whole code space, and each reset pattern is itself legal, so its
    // only predecessor is legal too. The compare therefore already yields 0
    // for every illegal state without a separate legality term.
    assign tc = (shift_q == rst_pat);

`ifdef RING_CNT_SELF_CORRECT_EN
    localparam logic [WIDTH-1:0] Q_ONE    = WIDTH'(1);
    localparam logic [WIDTH-2:0] EDGE_ONE = (WIDTH-1)'(1);

    logic [WIDTH-2:0] edges;
    logic             ring_legal;
    logic             johnson_legal;

    always_comb begin
        // One bit per adjacent pair that differs; a legal Johnson code has
        // at most one such boundary, a legal ring code exactly one hot bit.
        edges         = q_out[WIDTH-1:1] ^ q_out[WIDTH-2:0];
        ring_legal    = (q_out != '0) && ((q_out & (q_out - Q_ONE)) == '0);
        johnson_legal = ((edges & (edges - EDGE_ONE)) == '0);
        err           = mode_q ? ~johnson_legal : ~ring_legal;
    end
`else
    assign err = 1'b0;
`endif

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_out  <= RING_RST;
            mode_q <= 1'b0;
        end else if (mode != mode_q) begin
            q_out  <= mode ? JOHNSON_RST : RING_RST;
            mode_q <= mode;
        end else if (load) begin
            q_out <= load_val;
`ifdef RING_CNT_SELF_CORRECT_EN
        end else if (err) begin
            q_out <= rst_pat;
`endif
        end else if (en) begin
            q_out <= shift_q;
        end
    end

endmodule
